raster_test_source: RTL and testbench

Parametrised raster stimulus source for the CNN pipeline: scans a FRAME_W×FRAME_H screen, emitting one pixel per accepted beat with its screen_x/screen_y coordinates. It adds valid/ready backpressure, horizontal blanking, frame/line markers, a frame counter and selectable test patterns. It drives the `top` pipeline inputs in simulation and on-board bring-up, so the pipeline sees a camera-like stream without a camera.

---
 rtl/raster_pkg.sv | 16 +
 rtl/raster_counter.sv | 35 +++
 rtl/raster_test_source.sv | 161 ++++++++++++++++
 tb/tb_raster_test_source.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared definitions for the raster test source: pattern selectors and
// the sequencing states of the beat generator.
package raster_pkg;

  localparam logic [1:0] MODE_CONST   = 2'd0;
  localparam logic [1:0] MODE_XRAMP   = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_XORPAT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Scan-position pointer: walks x across a line, then y down the frame,
// wrapping to the origin after the last pixel of the frame.
module raster_counter #(
  parameter int FRAME_W = 36,
  parameter int FRAME_H = 36,
  parameter int X_W     = 6,
  parameter int Y_W     = 6
) (
  input  logic           clock,
  input  logic           advance,
  input  logic           clear,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_x,
  output logic           last_frame
);

  assign last_x     = (x == X_W'(FRAME_W - 1));
  assign last_frame = last_x && (y == Y_W'(FRAME_H - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_x) begin
        x <= '0;
        y <= last_frame ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/raster_test_source.sv
// Camera-like raster stream generator with valid/ready backpressure,
// horizontal blanking, frame/line markers and selectable test patterns.
module raster_test_source
  import raster_pkg::*;
#(
  parameter int FRAME_W = 36,
  parameter int FRAME_H = 36,
  parameter int X_W     = 6,
  parameter int Y_W     = 6,
  parameter int PIXEL_W = 9,
  parameter int HBLANK  = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] const_pixel,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [X_W-1:0]     screen_x,
  output logic [Y_W-1:0]     screen_y,
  output logic [PIXEL_W-1:0] pixel,
  output logic               frame_start,
  output logic               line_end,
  output logic               frame_end,
  output logic [7:0]         frame_count
);

  localparam int XY_W    = (X_W > Y_W) ? X_W : Y_W;
  localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  state_t               state_reg;
  logic [1:0]           mode_reg;
  logic [PIXEL_W-1:0]   const_reg;
  logic                 run_reg;
  logic [BLANK_W-1:0]   blank_cnt_reg;

  logic [X_W-1:0]       ptr_x;
  logic [Y_W-1:0]       ptr_y;
  logic                 ptr_last_x;
  logic                 ptr_last_frame;

  logic                 accept;
  logic                 load;
  logic                 at_origin;
  logic                 blank_done;
  logic [1:0]           load_mode;
  logic [PIXEL_W-1:0]   load_const;

  function automatic logic [PIXEL_W-1:0] pattern(
    input logic [1:0]         m,
    input logic [PIXEL_W-1:0] c,
    input logic [X_W-1:0]     px,
    input logic [Y_W-1:0]     py
  );
    case (m)
      MODE_CONST:   return c;
      MODE_XRAMP:   return PIXEL_W'(px);
      MODE_CHECKER: return (px[0] ^ py[0]) ? c : '0;
      default:      return PIXEL_W'(XY_W'(px) ^ XY_W'(py));
    endcase
  endfunction

  // The pointer names the beat to be loaded next; the output registers
  // hold the beat currently presented.
  raster_counter #(
    .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_counter (
    .clock     (clock),
    .advance   (load),
    .clear     (reset || (state_reg == IDLE && !enable)),
    .x         (ptr_x),
    .y         (ptr_y),
    .last_x    (ptr_last_x),
    .last_frame(ptr_last_frame)
  );

  assign accept     = out_valid && out_ready;
  assign at_origin  = (ptr_x == '0) && (ptr_y == '0);
  assign blank_done = (state_reg == BLANK) && (int'(blank_cnt_reg) == HBLANK - 1);
  assign load_mode  = at_origin ? mode : mode_reg;
  assign load_const = at_origin ? const_pixel : const_reg;

  always_comb begin
    load = 1'b0;
    case (state_reg)
      IDLE:    load = enable;
      ACTIVE:  load = accept && !(line_end && (HBLANK > 0)) && !(frame_end && !enable);
      BLANK:   load = blank_done && run_reg;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_CONST;
      const_reg     <= '0;
      run_reg       <= 1'b0;
      blank_cnt_reg <= '0;
      out_valid     <= 1'b0;
      screen_x      <= '0;
      screen_y      <= '0;
      pixel         <= '0;
      frame_start   <= 1'b0;
      line_end      <= 1'b0;
      frame_end     <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (load) begin
        state_reg   <= ACTIVE;
        out_valid   <= 1'b1;
        screen_x    <= ptr_x;
        screen_y    <= ptr_y;
        pixel       <= pattern(load_mode, load_const, ptr_x, ptr_y);
        frame_start <= at_origin;
        line_end    <= ptr_last_x;
        frame_end   <= ptr_last_frame;
        if (at_origin) begin
          mode_reg  <= mode;
          const_reg <= const_pixel;
        end
      end else if (accept) begin
        out_valid   <= 1'b0;
        frame_start <= 1'b0;
        line_end    <= 1'b0;
        frame_end   <= 1'b0;
      end

      if (accept && frame_end) begin
        frame_count <= frame_count + 8'd1;
      end

      // enable is only consulted when the last beat of a frame is taken.
      case (state_reg)
        ACTIVE: begin
          if (accept && line_end) begin
            if (HBLANK > 0) begin
              state_reg     <= BLANK;
              blank_cnt_reg <= '0;
              run_reg       <= !frame_end || enable;
            end else if (frame_end && !enable) begin
              state_reg <= IDLE;
            end
          end
        end
        BLANK: begin
          blank_cnt_reg <= blank_cnt_reg + 1'b1;
          if (blank_done) begin
            state_reg <= run_reg ? ACTIVE : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_test_source.sv
// Self-checking bench: two raster sources (36x36 no blanking, 4x2 with
// three blank cycles) checked every cycle against a behavioural model.
module tb_raster_test_source;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [8:0] const_pixel = 9'h040;

  logic       out_valid   [2];
  logic [5:0] screen_x    [2];
  logic [5:0] screen_y    [2];
  logic [8:0] pixel       [2];
  logic       frame_start [2];
  logic       line_end    [2];
  logic       frame_end   [2];
  logic [7:0] frame_count [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] spec_pixel(input int m, input logic [8:0] c,
                                            input int x, input int y);
    case (m)
      0:       return c;
      1:       return 9'(x);
      2:       return (((x ^ y) & 1) != 0) ? c : 9'h000;
      default: return 9'(x ^ y);
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int W  = (gi == 0) ? 36 : 4;
    localparam int H  = (gi == 0) ? 36 : 2;
    localparam int HB = (gi == 0) ? 0 : 3;

    raster_test_source #(
      .FRAME_W(W), .FRAME_H(H), .X_W(6), .Y_W(6), .PIXEL_W(9), .HBLANK(HB)
    ) dut (
      .clock      (clk),
      .reset      (reset),
      .enable     (enable),
      .mode       (mode),
      .const_pixel(const_pixel),
      .out_ready  (out_ready),
      .out_valid  (out_valid[gi]),
      .screen_x   (screen_x[gi]),
      .screen_y   (screen_y[gi]),
      .pixel      (pixel[gi]),
      .frame_start(frame_start[gi]),
      .line_end   (line_end[gi]),
      .frame_end  (frame_end[gi]),
      .frame_count(frame_count[gi])
    );

    // Model: expected position (ex,ey), remaining blank cycles, idle flag.
    int ex = 0, ey = 0, gap = 0, fc = 0, lm = 0, beats = 0;
    bit ev = 0, idle = 1, cont = 0, live = 0, le = 0, fe = 0;
    logic [8:0] lc = 9'h000;

    always @(posedge clk) begin
      if (reset) begin
        ev = 0; ex = 0; ey = 0; gap = 0; fc = 0; idle = 1; live = 1;
      end else if (idle) begin
        if (enable) begin
          idle = 0; ev = 1; ex = 0; ey = 0; lm = mode; lc = const_pixel;
        end
      end else if (gap > 0) begin
        gap--;
        if (gap == 0) begin
          if (cont) begin
            ev = 1;
            if (ex == 0 && ey == 0) begin lm = mode; lc = const_pixel; end
          end else begin
            idle = 1;
          end
        end
      end else if (out_ready) begin
        le = (ex == W - 1);
        fe = le && (ey == H - 1);
        if (fe) fc = (fc + 1) % 256;
        if (le) begin ex = 0; ey = (ey + 1) % H; end else ex++;
        cont = !fe || enable;
        if (le && HB > 0) begin ev = 0; gap = HB; end
        else if (!cont) begin ev = 0; idle = 1; end
        else if (ex == 0 && ey == 0) begin lm = mode; lc = const_pixel; end
      end
    end

    always @(negedge clk) begin
      if (live) begin
        check("out_valid", gi, 32'(out_valid[gi]), 32'(ev));
        check("frame_count", gi, 32'(frame_count[gi]), 32'(fc));
        if (ev) begin
          check("screen_x", gi, 32'(screen_x[gi]), 32'(ex));
          check("screen_y", gi, 32'(screen_y[gi]), 32'(ey));
          check("pixel", gi, 32'(pixel[gi]), 32'(spec_pixel(lm, lc, ex, ey)));
          check("frame_start", gi, 32'(frame_start[gi]), 32'(ex == 0 && ey == 0));
          check("line_end", gi, 32'(line_end[gi]), 32'(ex == W - 1));
          check("frame_end", gi, 32'(frame_end[gi]), 32'(ex == W - 1 && ey == H - 1));
        end else begin
          check("markers_idle", gi,
                32'({frame_start[gi], line_end[gi], frame_end[gi]}), 32'(0));
        end
        if (reset) begin
          beats = 0;
        end else if (out_valid[gi] && out_ready) begin
          beats++;
          if (frame_end[gi]) begin
            check("beats_per_frame", gi, 32'(beats), 32'(W * H));
            beats = 0;
          end
        end
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xy(input int x, input int y);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (out_valid[0] && screen_x[0] == 6'(x) && screen_y[0] == 6'(y)) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_xy timeout: beat (%0d,%0d) never presented", x, y);
  endtask

  int c0;

  initial begin
    repeat (3) drive_slot();
    @(negedge clk);
    check("reset_valid", 0, 32'(out_valid[0]), 32'(0));
    check("reset_pixel", 0, 32'(pixel[0]), 32'(0));
    check("reset_count", 1, 32'(frame_count[1]), 32'(0));
    drive_slot();
    reset = 1'b0;
    drive_slot();
    enable = 1'b1;
    @(negedge clk);
    check("idle_before_enable", 0, 32'(out_valid[0]), 32'(0));
    @(negedge clk);
    check("first_valid", 0, 32'(out_valid[0]), 32'(1));
    check("first_xy", 0, 32'({screen_x[0], screen_y[0]}), 32'(0));
    check("first_pixel", 0, 32'(pixel[0]), 32'(9'h040));

    // Reset in the middle of the first frame.
    wait_xy(7, 3);
    drive_slot();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset_valid", 0, 32'(out_valid[0]), 32'(0));
    check("midreset_xy", 0, 32'({screen_x[0], screen_y[0]}), 32'(0));
    check("midreset_count", 0, 32'(frame_count[0]), 32'(0));
    drive_slot();
    reset = 1'b0;

    // Full-rate frame period.
    wait_xy(0, 0);
    c0 = cyc;
    for (int i = 0; i < 3000 && frame_count[0] != 8'd1; i++) @(negedge clk);
    check("frame_period_36x36", 0, 32'(cyc - c0), 32'(1296));
    for (int i = 0; i < 100 && !(out_valid[1] && frame_start[1]); i++) @(negedge clk);
    c0 = cyc;
    @(negedge clk);
    for (int i = 0; i < 100 && !(out_valid[1] && frame_start[1]); i++) @(negedge clk);
    check("frame_period_4x2_hblank3", 1, 32'(cyc - c0), 32'(14));

    // Checkerboard, then a mid-frame switch to the ramp.
    drive_slot();
    mode = 2'd2;
    const_pixel = 9'h100;
    wait_xy(35, 35);
    wait_xy(0, 0);
    check("checker_0_0", 0, 32'(pixel[0]), 32'(9'h000));
    wait_xy(1, 0);
    check("checker_1_0", 0, 32'(pixel[0]), 32'(9'h100));
    wait_xy(1, 1);
    check("checker_1_1", 0, 32'(pixel[0]), 32'(9'h000));
    wait_xy(3, 5);
    drive_slot();
    mode = 2'd1;
    wait_xy(4, 5);
    check("midframe_mode_held", 0, 32'(pixel[0]), 32'(9'h100));
    wait_xy(5, 0);
    check("xramp_5_0", 0, 32'(pixel[0]), 32'(9'h005));

    // Random backpressure with occasional pattern changes.
    for (int i = 0; i < 3500; i++) begin
      drive_slot();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        mode = 2'($urandom_range(0, 3));
        const_pixel = 9'($urandom);
      end
    end
    drive_slot();
    out_ready = 1'b1;

    // Drop enable mid-frame: the frame finishes, then both go idle.
    wait_xy(5, 10);
    drive_slot();
    enable = 1'b0;
    wait_xy(35, 35);
    repeat (8) @(negedge clk);
    check("stopped_valid", 0, 32'(out_valid[0]), 32'(0));
    check("stopped_valid", 1, 32'(out_valid[1]), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
